// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and default sizing shared by mem_arbiter and rr_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT = 2;
  localparam int ADDR_W_DEFAULT  = 4;
  localparam int DATA_W_DEFAULT  = 32;
  localparam int TIMEOUT_DEFAULT = 15;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick. Scans the request vector upward
// from ptr with wrap-around and returns the first hit as one-hot and as index.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = idx_width(NUM_REQ_DEFAULT)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W:0]   wrap_s;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk the candidates in priority order; the first requesting one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum_s     = '0;
    wrap_s    = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s         = {1'b0, ptr} + (IDX_W+1)'(i);
      wrap_s        = sum_s - (IDX_W+1)'(NUM_REQ);
      cand_s        = (sum_s >= (IDX_W+1)'(NUM_REQ)) ? wrap_s[IDX_W-1:0] : sum_s[IDX_W-1:0];
      hit_s         = !grant_any && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      grant_any     = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer in front of a single-port memory.
// One transaction in flight: IDLE (grant) -> ISSUE (one enable pulse) ->
// WAIT (reads only, until valid_out) -> RESP (one-cycle completion strobe).
// Optional build macro MEM_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and
// reports an expired wait through rsp_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_valid_out
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t         state_r, state_next_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_next_s;
  logic [IDX_W-1:0]   owner_r, owner_next_s;
  logic               write_r, write_next_s;
  logic               rd_en_r, rd_en_next_s;
  logic               wr_en_r, wr_en_next_s;
  logic [ADDR_W-1:0]  addr_r, addr_next_s;
  logic [DATA_W-1:0]  wdata_r, wdata_next_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_next_s;
  logic [DATA_W-1:0]  rsp_rdata_r, rsp_rdata_next_s;
  logic               rsp_err_r, rsp_err_next_s;
  logic               busy_r, busy_next_s;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  logic               accept_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = idx_width(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_next_s;
`else
  // TIMEOUT only shapes the bounded-wait build; keep it referenced here.
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT > 0);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // A grant happens only in IDLE, and reset in the same cycle suppresses it.
  assign accept_s  = (state_r == IDLE) && grant_any_s && !rst;
  assign req_ready = accept_s ? grant_s : '0;

  assign rsp_valid        = rsp_valid_r;
  assign rsp_rdata        = rsp_rdata_r;
  assign rsp_err          = rsp_err_r;
  assign busy             = busy_r;
  assign mem_read_enable  = rd_en_r;
  assign mem_write_enable = wr_en_r;
  assign mem_addr         = addr_r;
  assign mem_data_in      = wdata_r;

  // Next state plus next value of every registered output.
  always_comb begin
    state_next_s     = state_r;
    rr_ptr_next_s    = rr_ptr_r;
    owner_next_s     = owner_r;
    write_next_s     = write_r;
    addr_next_s      = addr_r;
    wdata_next_s     = wdata_r;
    rd_en_next_s     = 1'b0;
    wr_en_next_s     = 1'b0;
    rsp_valid_next_s = '0;
    rsp_rdata_next_s = '0;
    rsp_err_next_s   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_cnt_next_s  = '0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s  = ISSUE;
          owner_next_s  = grant_idx_s;
          write_next_s  = req_write[grant_idx_s];
          addr_next_s   = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
          wdata_next_s  = req_wdata[grant_idx_s*DATA_W +: DATA_W];
          rr_ptr_next_s = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
          wr_en_next_s  = req_write[grant_idx_s];
          rd_en_next_s  = !req_write[grant_idx_s];
        end else begin
          state_next_s  = IDLE;
        end
      end
      ISSUE: begin
        if (write_r) begin
          state_next_s              = RESP;
          rsp_valid_next_s[owner_r] = 1'b1;
        end else begin
          state_next_s              = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid_out) begin
          state_next_s              = RESP;
          rsp_valid_next_s[owner_r] = 1'b1;
          rsp_rdata_next_s          = mem_data_out;
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
          if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_next_s              = RESP;
            rsp_valid_next_s[owner_r] = 1'b1;
            rsp_err_next_s            = 1'b1;
          end else begin
            wait_cnt_next_s           = wait_cnt_r + CNT_W'(1);
          end
`else
          state_next_s = WAIT;
`endif
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // State, round-robin pointer, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      write_r     <= 1'b0;
      rd_en_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rr_ptr_r    <= rr_ptr_next_s;
      owner_r     <= owner_next_s;
      write_r     <= write_next_s;
      rd_en_r     <= rd_en_next_s;
      wr_en_r     <= wr_en_next_s;
      addr_r      <= addr_next_s;
      wdata_r     <= wdata_next_s;
      rsp_valid_r <= rsp_valid_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
      rsp_err_r   <= rsp_err_next_s;
      busy_r      <= busy_next_s;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Cycles spent in WAIT for the current read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized bench for mem_arbiter with a
// latency-programmable memory responder and a transaction-level reference
// (round-robin pick, shadow memory, expected response cycle).
module tb_mem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int TMO  = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, mem_data_in, mem_data_out;
  logic                 rsp_err, busy, mem_read_enable, mem_write_enable, mem_valid_out;
  logic [AW-1:0]        mem_addr;

  mem_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester-side state and reference model.
  bit            rq_wr   [NREQ];
  logic [AW-1:0] rq_addr [NREQ];
  logic [DW-1:0] rq_data [NREQ];
  int            rq_lat  [NREQ];
  logic [DW-1:0] shadow  [16];
  int            ptr_m;
  int            mem_lat = 1;

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Memory responder: stores writes, answers a read mem_lat cycles after
  // read_enable (0 = never), and drives junk on data_out otherwise.
  logic [DW-1:0] mem_arr [16];
  logic          pending;
  int            lat_cnt;
  logic [AW-1:0] pend_addr;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= pat(i);
      pending       <= 1'b0;
      lat_cnt       <= 0;
      pend_addr     <= '0;
      mem_valid_out <= 1'b0;
      mem_data_out  <= '0;
    end else begin
      mem_valid_out <= 1'b0;
      mem_data_out  <= $urandom;
      if (mem_write_enable) mem_arr[mem_addr] <= mem_data_in;
      if (mem_read_enable) begin
        if (mem_lat == 1) begin
          mem_valid_out <= 1'b1;
          mem_data_out  <= mem_arr[mem_addr];
        end else if (mem_lat > 1) begin
          pending   <= 1'b1;
          lat_cnt   <= mem_lat - 1;
          pend_addr <= mem_addr;
        end
      end else if (pending) begin
        if (lat_cnt == 1) begin
          mem_valid_out <= 1'b1;
          mem_data_out  <= mem_arr[pend_addr];
          pending       <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]           = rq_wr[i];
      req_addr[i*AW +: AW]   = rq_addr[i];
      req_wdata[i*DW +: DW]  = rq_data[i];
    end
  endtask

  task automatic new_req(input int i);
    rq_wr[i]   = 1'($urandom_range(0, 1));
    rq_addr[i] = 4'($urandom_range(0, 15));
    rq_data[i] = $urandom;
    rq_lat[i]  = $urandom_range(1, 4);
  endtask

  task automatic reset_model();
    ptr_m = 0;
    for (int i = 0; i < 16; i++) shadow[i] = pat(i);
  endtask

  // Reference pick: first valid requester at or above ptr_m, wrapping.
  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  // One complete transaction with cycle-exact checks. mode: 0 = winner drops
  // its request, 1 = all keep requesting (winner gets a fresh request),
  // 2 = fresh request plus a random nonzero valid mask.
  task automatic serve(input int mode, output int g_obs);
    int eg, n, delay;
    bit wr, tmo;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d, exp_data;
    logic [NREQ-1:0] exp_oh;
    #1;
    eg = model_grant();
    exp_oh = '0;
    if (eg >= 0) exp_oh[eg] = 1'b1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 32'(req_ready), 32'(exp_oh));
    g_obs = (req_ready == 2'b01) ? 0 : ((req_ready == 2'b10) ? 1 : -1);
    if (req_ready != exp_oh || eg < 0) return;
    ptr_m   = (eg + 1) % NREQ;
    wr      = rq_wr[eg];
    a       = rq_addr[eg];
    d       = rq_data[eg];
    mem_lat = wr ? 1 : rq_lat[eg];
    tmo     = !wr && (mem_lat == 0);
`ifdef MEM_ARB_TIMEOUT_EN
    if (!wr && mem_lat > TMO) tmo = 1'b1;
`endif
    if (wr) shadow[a] = d;
    exp_data = (wr || tmo) ? '0 : shadow[a];
    delay    = wr ? 1 : (tmo ? 1 + TMO : 1 + mem_lat);
    @(negedge clk);
    if (mode == 0) begin
      req_valid[eg] = 1'b0;
    end else begin
      new_req(eg);
      if (mode == 2) req_valid = 2'($urandom_range(1, 3));
      drive_reqs();
    end
    chk("mem_we", 32'(mem_write_enable), 32'(wr));
    chk("mem_re", 32'(mem_read_enable), 32'(!wr));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    if (wr) chk("mem_din", mem_data_in, d);
    chk("busy_issue", 32'(busy), 32'd1);
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      chk("rsp_early", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
    chk("rsp_rdata", rsp_rdata, exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(tmo));
    @(negedge clk);
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n;
    // Reset with a request present: reset wins, all outputs low.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    drive_reqs();
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_re", 32'(mem_read_enable), 32'd0);
    chk("rst_we", 32'(mem_write_enable), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", mem_data_in, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    // req0 writes 0xDEADBEEF to addr 3, then req1 reads it back (latency 1).
    rq_wr[0] = 1'b1; rq_addr[0] = 4'd3; rq_data[0] = 32'hDEAD_BEEF;
    drive_reqs();
    req_valid = 2'b01;
    serve(0, g);
    chk("wr_grant", 32'(g), 32'd0);
    rq_wr[1] = 1'b0; rq_addr[1] = 4'd3; rq_lat[1] = 1;
    drive_reqs();
    req_valid = 2'b10;
    serve(0, g);
    chk("rd_grant", 32'(g), 32'd1);

    // Two continuous requesters alternate 0,1,0,1,0,1.
    new_req(0); new_req(1); drive_reqs();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      serve(1, g);
      chk("alternate", 32'(g), 32'(i % 2));
    end
    req_valid = '0;

    // Randomized traffic with changing request masks and read latencies.
    new_req(0); new_req(1); drive_reqs();
    req_valid = 2'($urandom_range(1, 3));
    for (int i = 0; i < 40; i++) serve(2, g);
    req_valid = '0;

    // Reset during WAIT of req0's read: discarded, next grant goes to req0.
    rq_wr[0] = 1'b0; rq_addr[0] = 4'd5; drive_reqs();
    mem_lat = 0;
    req_valid = 2'b01;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("rw_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    chk("rw_re", 32'(mem_read_enable), 32'd1);
    @(negedge clk);
    chk("rw_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("rw_rst_wins", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_rsp", 32'(rsp_valid), 32'd0);
    chk("rw_re_low", 32'(mem_read_enable), 32'd0);
    chk("rw_we_low", 32'(mem_write_enable), 32'd0);
    rst = 1'b0;
    reset_model();
    new_req(0); new_req(1); drive_reqs();
    serve(0, g);
    chk("rw_next_grant", 32'(g), 32'd0);
    req_valid = '0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: error response after TIMEOUT wait cycles.
    rq_wr[0] = 1'b0; rq_addr[0] = 4'd7; rq_lat[0] = 0; drive_reqs();
    req_valid = 2'b01;
    serve(0, g);
    // valid_out on the last allowed WAIT cycle wins over the timeout.
    rq_lat[0] = TMO; req_valid = 2'b01;
    serve(0, g);
    // One cycle too late: timeout, and the late valid_out is ignored.
    rq_lat[0] = TMO + 1; req_valid = 2'b01;
    serve(0, g);
`else
    // Silent memory without timeout: the arbiter stays busy indefinitely.
    rq_wr[0] = 1'b0; rq_addr[0] = 4'd7; drive_reqs();
    mem_lat = 0;
    req_valid = 2'b01;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("hang_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("hang_busy", 32'(busy), 32'd1);
      chk("hang_rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single-port 16x32 memory between `NUM_REQ` requesters. It accepts one read or write request at a time over a valid/ready handshake and drives the memory's `read_enable`/`write_enable`/`addr`/`data_in` pins. For reads it waits for `valid_out` and returns `data_out` to the winning requester. It sits between the requester clients and the memory, on the memory's clock.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters.
- `ADDR_W`, 4: memory address width.
- `DATA_W`, 32: memory data width.
- `TIMEOUT`, 15: maximum cycles spent in WAIT. Used only with the timeout macro.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i owns slice i.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_ready`  out  NUM_REQ  one-hot acceptance strobe.
- `rsp_valid`  out  NUM_REQ  one-hot completion strobe.
- `rsp_rdata`  out  DATA_W  read data; valid while any `rsp_valid` bit is set.
- `rsp_err`  out  1  timeout flag; qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `mem_read_enable`  out  1  to memory `read_enable`.
- `mem_write_enable`  out  1  to memory `write_enable`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_data_in`  out  DATA_W  to memory `data_in`.
- `mem_data_out`  in  DATA_W  from memory `data_out`.
- `mem_valid_out`  in  1  from memory `valid_out`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` bit is set, grant the first set bit searching upward from `rr_ptr`, wrapping around.
  - `req_ready[g]` is combinational high in this cycle.
  - Latch write, addr and wdata of the winner; set `rr_ptr` = (g+1) mod NUM_REQ; go to ISSUE.
- **ISSUE:**
  - Exactly one of `mem_read_enable`/`mem_write_enable` is high for exactly one cycle, with latched `mem_addr`/`mem_data_in`.
  - A write goes to RESP; a read goes to WAIT.
- **WAIT:** on `mem_valid_out`=1, capture `mem_data_out` and go to RESP. Both memory enables are low.
- **RESP:**
  - `rsp_valid[g]` is high for one cycle.
  - `rsp_rdata` holds the captured data for reads and 0 for writes.
  - Next state is IDLE.
- `mem_valid_out` is ignored outside WAIT.
- Requesters hold their request stable until `req_ready`. Dropping `req_valid` before grant withdraws the request without side effects.
- No request is accepted outside IDLE, so there is exactly one outstanding transaction.
- `rr_ptr` rules:
  - It advances only on a grant.
  - A lone requester is served back-to-back.
  - Two continuously requesting clients alternate strictly.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, and all outputs 0 (`req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy`, both mem enables, `mem_addr`, `mem_data_in`).
- Write: accept at cycle N, `mem_write_enable` at N+1, `rsp_valid` at N+2, next accept no earlier than N+3.
- Read: accept at N, `mem_read_enable` at N+1, `mem_valid_out` first sampled at N+2. If `valid_out` arrives at N+1+k (k≥1), `rsp_valid` is at N+2+k.
- All mem outputs and `rsp_*` are registered. `req_ready` is the only combinational output.
- Reset is synchronous: `rst` high at any edge returns the block to IDLE on that edge and drops both enables. An in-flight transaction is discarded with no `rsp_valid`.
- If `rst` and a request are present together, reset wins: no `req_ready`.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A counter runs in WAIT.
  - If `TIMEOUT` cycles pass with no `mem_valid_out`, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - A `valid_out` arriving on the same cycle as the timeout wins, with `rsp_err`=0.
- Without the macro: WAIT is unbounded, `rsp_err` is tied to 0, and the port remains present.

## Structure
- Package `mem_arb_pkg`: the `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP) and default constants for `ADDR_W`, `DATA_W` and `TIMEOUT`.
- Sub-module `rr_arbiter`: combinational round-robin grant from `req_valid` and `rr_ptr`, producing a one-hot grant and its index. It is instantiated once.

## Test plan
- Reset, then req0 writes 0xDEADBEEF to addr 3 → `req_ready[0]` at N, `mem_write_enable`=1 with addr 3 at N+1, `rsp_valid[0]` at N+2.
- req1 reads addr 3 with the memory model returning `valid_out` 1 cycle after `read_enable` → `rsp_valid[1]` at N+3 with `rsp_rdata`=0xDEADBEEF.
- req0 and req1 request continuously for 6 transactions → grants 0,1,0,1,0,1.
- Assert `rst` during WAIT of a read → IDLE on the next edge, no `rsp_valid`, `busy`=0, next grant to requester 0.
- `MEM_ARB_TIMEOUT_EN` with the memory never asserting `valid_out`, `TIMEOUT`=15 → `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 after 15 WAIT cycles. Without the macro → `busy` stays 1.
